// File: rtl/pic_seq.sv
// pic_seq: four-phase instruction-cycle sequencer with flush, return-stack tracking,
// debug halt/single-step and a retired-instruction counter.
module pic_seq #(
    parameter int STACK_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             halt_req_i,
    input  logic             step_req_i,
    input  logic             is_call_i,
    input  logic             is_ret_i,
    input  logic             is_branch_i,
    input  logic             skip_taken_i,
    output logic [1:0]       phase_o,
    output logic             rd_en_o,
    output logic             exec_en_o,
    output logic             fetch_en_o,
    output logic             flush_o,
    output logic             stack_push_o,
    output logic             stack_pop_o,
    output logic [1:0]       stack_level_o,
    output logic             stack_ovf_o,
    output logic             stack_unf_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] instret_o
);
    typedef enum logic [1:0] {FILL, RUN, HALTED, STEP} state_t;

    localparam logic [1:0] DEPTH = 2'(STACK_DEPTH);

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d, level_q, level_d;
    logic             pend_q, pend_d, flush_q, flush_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active, q4, ctrl;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= FILL;
            phase_q <= 2'd0;
            level_q <= 2'd0;
            pend_q  <= 1'b0;
            flush_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            level_q <= level_d;
            pend_q  <= pend_d;
            flush_q <= flush_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q + 2'd1;
        level_d      = level_q;
        flush_d      = flush_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        cnt_d        = cnt_q;
        active       = state_q == RUN || state_q == STEP;
        q4           = phase_q == 2'd3;
        rd_en_o      = active && !flush_q && phase_q == 2'd1;
        exec_en_o    = active && !flush_q && phase_q == 2'd2;
        fetch_en_o   = state_q != HALTED && q4;
        stack_push_o = exec_en_o && is_call_i;
        stack_pop_o  = exec_en_o && is_ret_i && !is_call_i;
        ctrl         = exec_en_o && (is_call_i || is_ret_i || is_branch_i || skip_taken_i);
        pend_d       = pend_q || ctrl;
        if (stack_push_o) begin
            level_d = level_q == DEPTH ? level_q : level_q + 2'd1;
            ovf_d   = ovf_q || level_q == DEPTH;
        end
        if (stack_pop_o) begin
            level_d = level_q == 2'd0 ? 2'd0 : level_q - 2'd1;
            unf_d   = unf_q || level_q == 2'd0;
        end
        if (state_q == HALTED) begin
            phase_d = 2'd0;
            state_d = !halt_req_i ? RUN : step_req_i ? STEP : HALTED;
        end else if (q4) begin
            // flush_q stays frozen across HALTED, so a pending flush survives a halt
            flush_d = pend_q;
            pend_d  = 1'b0;
            cnt_d   = active && !flush_q ? cnt_q + CNT_W'(1) : cnt_q;
            state_d = state_q == STEP ? HALTED : state_q == FILL ? RUN : halt_req_i ? HALTED : RUN;
        end
    end

    assign phase_o       = phase_q;
    assign flush_o       = flush_q;
    assign stack_level_o = level_q;
    assign stack_ovf_o   = ovf_q;
    assign stack_unf_o   = unf_q;
    assign halted_o      = state_q == HALTED;
    assign instret_o     = cnt_q;
endmodule

// File: tb/tb_pic_seq.sv
// tb_pic_seq: instruction-level reference model driving pic_seq with directed and random cycles.
module tb_pic_seq;
    localparam int SD = 2;
    localparam int CW = 4;

    logic clk = 0, rst_n = 1;
    logic halt_req = 0, step_req = 0, is_call = 0, is_ret = 0, is_branch = 0, skip_taken = 0;
    logic [1:0] phase, stack_level;
    logic rd_en, exec_en, fetch_en, flush, stack_push, stack_pop, stack_ovf, stack_unf, halted;
    logic [CW-1:0] instret;

    int checks = 0, errors = 0;
    int m_mode;             // 0 fill, 1 run, 2 halted, 3 step
    bit m_flush, m_ovf, m_unf;
    int m_level, m_cnt;

    always #5 clk = ~clk;

    pic_seq #(.STACK_DEPTH(SD), .CNT_W(CW)) dut (
        .clock_i(clk), .reset_ni(rst_n), .halt_req_i(halt_req), .step_req_i(step_req),
        .is_call_i(is_call), .is_ret_i(is_ret), .is_branch_i(is_branch), .skip_taken_i(skip_taken),
        .phase_o(phase), .rd_en_o(rd_en), .exec_en_o(exec_en), .fetch_en_o(fetch_en),
        .flush_o(flush), .stack_push_o(stack_push), .stack_pop_o(stack_pop),
        .stack_level_o(stack_level), .stack_ovf_o(stack_ovf), .stack_unf_o(stack_unf),
        .halted_o(halted), .instret_o(instret)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input int ph, input bit rd, input bit ex,
                               input bit fe, input bit pu, input bit po, input bit ha);
        chk({tag, ".phase"}, 32'(phase), 32'(ph));
        chk({tag, ".rd_en"}, 32'(rd_en), 32'(rd));
        chk({tag, ".exec_en"}, 32'(exec_en), 32'(ex));
        chk({tag, ".fetch_en"}, 32'(fetch_en), 32'(fe));
        chk({tag, ".flush"}, 32'(flush), 32'(m_flush));
        chk({tag, ".push"}, 32'(stack_push), 32'(pu));
        chk({tag, ".pop"}, 32'(stack_pop), 32'(po));
        chk({tag, ".halted"}, 32'(halted), 32'(ha));
        chk({tag, ".level"}, 32'(stack_level), 32'(m_level));
        chk({tag, ".ovf"}, 32'(stack_ovf), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(stack_unf), 32'(m_unf));
        chk({tag, ".instret"}, 32'(instret), 32'(m_cnt));
    endtask

    // One full instruction cycle; c/r/b/s are presented at Q3, noise elsewhere.
    task automatic do_cycle(input string tag, input bit c, input bit r, input bit b,
                            input bit s, input bit hreq);
        bit ex = (m_mode == 1 || m_mode == 3) && !m_flush;
        bit nf = 0;
        for (int p = 0; p < 4; p++) begin
            halt_req   = (p == 0) ? 1'($urandom) : hreq;
            step_req   = 1'($urandom);
            is_call    = (p == 2) ? c : 1'($urandom);
            is_ret     = (p == 2) ? r : 1'($urandom);
            is_branch  = (p == 2) ? b : 1'($urandom);
            skip_taken = (p == 2) ? s : 1'($urandom);
            #1;
            expect_outs($sformatf("%s.q%0d", tag, p + 1), p, ex && p == 1, ex && p == 2, p == 3,
                        ex && p == 2 && c, ex && p == 2 && r && !c, 0);
            if (p == 2 && ex) begin
                if (c) begin
                    if (m_level == SD) m_ovf = 1; else m_level++;
                end else if (r) begin
                    if (m_level == 0) m_unf = 1; else m_level--;
                end
                nf = c | r | b | s;
            end
            if (p == 3 && ex) m_cnt = (m_cnt + 1) % (1 << CW);
            @(negedge clk);
        end
        m_flush = nf;
        m_mode  = (m_mode == 3) ? 2 : (m_mode == 0) ? 1 : hreq ? 2 : 1;
    endtask

    task automatic halt_clk(input bit hreq, input bit sreq);
        halt_req   = hreq;
        step_req   = sreq;
        is_call    = 1'($urandom);
        is_ret     = 1'($urandom);
        is_branch  = 1'($urandom);
        skip_taken = 1'($urandom);
        #1;
        expect_outs("halt", 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        m_mode = !hreq ? 1 : sreq ? 3 : 2;
    endtask

    task automatic model_reset();
        m_mode = 0; m_flush = 0; m_ovf = 0; m_unf = 0; m_level = 0; m_cnt = 0;
    endtask

    initial begin
        model_reset();
        #2 rst_n = 0;
        #1 expect_outs("reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        do_cycle("fill", 0, 0, 0, 0, 0);
        do_cycle("run1", 0, 0, 0, 0, 0);
        do_cycle("run2", 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            do_cycle("call", 1, 0, 0, 0, 0);
            do_cycle("callfl", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
        end
        for (int i = 0; i < 3; i++) begin
            do_cycle("ret", 0, 1, 0, 0, 0);
            do_cycle("retfl", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
        end
        do_cycle("callret", 1, 1, 0, 0, 0);
        do_cycle("crfl", 0, 0, 0, 0, 0);
        do_cycle("skip", 0, 0, 0, 1, 0);
        do_cycle("skipfl", 1, 1, 1, 1, 0);
        do_cycle("after", 0, 0, 0, 0, 0);
        do_cycle("hreq", 0, 0, 0, 0, 1);
        halt_clk(1, 0);
        halt_clk(1, 0);
        halt_clk(1, 1);
        do_cycle("step", 0, 0, 0, 0, 1);
        halt_clk(1, 0);
        halt_clk(0, 0);
        do_cycle("resume", 0, 0, 0, 0, 0);
        do_cycle("brhalt", 0, 0, 1, 0, 1);
        halt_clk(1, 0);
        halt_clk(0, 0);
        do_cycle("pendfl", 0, 0, 0, 0, 0);
        do_cycle("postfl", 0, 0, 0, 0, 0);
        for (int i = 0; i < 80; i++) begin
            if (m_mode == 2) halt_clk($urandom_range(0, 2) != 0, 1'($urandom));
            else do_cycle("rand", $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                          $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0,
                          $urandom_range(0, 7) == 0);
        end
        for (int i = 0; i < 10 && !(m_mode == 1 && !m_flush); i++) begin
            if (m_mode == 2) halt_clk(0, 0);
            else do_cycle("drain", 0, 0, 0, 0, 0);
        end
        chk("drain.mode", 32'(m_mode == 1 && !m_flush), 32'd1);
        halt_req = 0; is_call = 0; is_ret = 0; is_branch = 0; skip_taken = 0;
        @(negedge clk);
        @(negedge clk);
        is_call = 1;
        #1;
        chk("prereset.exec", 32'(exec_en), 32'd1);
        chk("prereset.push", 32'(stack_push), 32'd1);
        rst_n = 0;
        model_reset();
        #1 expect_outs("midreset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        do_cycle("refill", 0, 0, 0, 0, 0);
        do_cycle("rerun", 1, 0, 0, 0, 0);
        do_cycle("rerunfl", 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pic_seq.md
Name: pic_seq

Overview:
- Instruction-cycle sequencer for the structural PIC core.
- Divides each instruction into four clock phases (Q1..Q4) and produces the phase strobes that gate controller enables: read at Q2, execute/write at Q3, fetch at Q4.
- Flushes the prefetched instruction after control-flow changes and skips.
- Tracks return-stack depth, with sticky overflow/underflow flags.
- Provides a debug halt/single-step handshake and a retired-instruction counter.

Parameters:
- STACK_DEPTH, 2, number of return-stack levels tracked (1..3).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- halt_req  input  1  debug halt request (level).
- step_req  input  1  single-step request (1-clock pulse, honoured only when halted).
- is_call  input  1  decoded CALL in current instruction.
- is_ret  input  1  decoded RETLW in current instruction.
- is_branch  input  1  GOTO or write to PC.
- skip_taken  input  1  skip condition true (BTFSx/DECFSZ/INCFSZ).
- phase  output  2  current phase: 0=Q1, 1=Q2, 2=Q3, 3=Q4.
- rd_en  output  1  operand-read strobe (Q2 of executing cycle).
- exec_en  output  1  write/execute strobe (Q3 of executing cycle).
- fetch_en  output  1  instruction-register load strobe (Q4).
- flush  output  1  current instruction cycle is a forced NOP.
- stack_push  output  1  1-clock push pulse.
- stack_pop  output  1  1-clock pop pulse.
- stack_level  output  2  current stack occupancy.
- stack_ovf  output  1  sticky overflow flag.
- stack_unf  output  1  sticky underflow flag.
- halted  output  1  core halted (acknowledge for halt_req).
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (reset=0, asynchronous) forces state=FILL, phase=Q1, and clears all outputs: strobes, flush, halted, stack_level, ovf, unf, instret.
- States:
  - FILL: one instruction cycle after reset. Phase runs Q1..Q4. fetch_en fires at Q4. rd_en and exec_en stay low. Go to RUN after that Q4.
  - RUN: phase increments every clock, wrapping Q4 to Q1. If flush=0: rd_en=1 at Q2, exec_en=1 at Q3. fetch_en=1 at Q4 always.
  - HALTED: phase held at Q1. All strobes low. halted=1.
  - STEP: exactly one instruction cycle, same strobes as RUN, then return to HALTED.
- Transitions:
  - At Q4 in RUN, if halt_req=1, enter HALTED on the next clock.
  - In HALTED, halt_req=0 enters RUN (phase Q1) on the next clock.
  - In HALTED, step_req=1 with halt_req=1 enters STEP.
  - If halt_req and step_req are both low in HALTED, halt_req low wins and the core resumes.
- Control flow is sampled at Q3 only when exec_en=1:
  - is_call: stack_push pulses at that Q3 clock. stack_level increments, saturating at STACK_DEPTH. If the level was already STACK_DEPTH, set stack_ovf.
  - is_ret: stack_pop pulses. stack_level decrements. If the level was 0, set stack_unf and keep the level at 0.
  - is_call and is_ret both high: treat as call only.
  - If any of is_call, is_ret, is_branch or skip_taken is high, set a flush-pending flag.
- Flush:
  - flush goes high at the next Q1 and stays high for that whole instruction cycle.
  - During the flushed cycle exec_en and rd_en are suppressed and control inputs are ignored.
  - flush clears after the Q4 of the flushed cycle. fetch_en still fires at that Q4.
  - A flush pending at halt entry is preserved through HALTED.
- instret: increments at Q4 of each RUN/STEP cycle with flush=0. FILL and flushed cycles do not count. Wraps 2^CNT_W-1 to 0.
- stack_ovf and stack_unf clear only on reset.
- Reset mid-cycle aborts immediately, with no completing pulses.

Test Plan:
- Reset release, halt_req=0, no control inputs: fetch_en at clocks 4, 8, 12; first exec_en at clock 7; instret=1 after clock 8.
- Three CALL instructions with STACK_DEPTH=2: stack_push pulses 3 times; stack_level goes 1, 2, 2; stack_ovf=1 after the third. Each call flushes the following cycle, so instret=3.
- RETLW at level 0: stack_pop pulses; stack_unf=1; stack_level=0; next cycle flush=1 with exec_en low.
- skip_taken=1 at Q3: next cycle flush=1, rd_en and exec_en low, instret unchanged; the following cycle executes normally.
- halt_req raised at Q2: Q3 and Q4 complete, then halted=1 with phase frozen at Q1. A step_req pulse gives exactly one exec_en pulse, instret+1, back to halted. Dropping halt_req gives RUN the next clock.
- reset asserted at Q3 with is_call=1: no stack_push. All outputs read 0 immediately. On release the block re-enters FILL.
